// File: rtl/asp_host_tx.sv
// asp_host_tx
//   Host-side transmit buffer. Host words are stored in a small FIFO together
//   with an even-parity bit. The parity bit can be deliberately corrupted for
//   error-path testing. An issue FSM (IDLE -> ISSUE -> GAP -> IDLE) sends one
//   buffered word per ISSUE cycle. It then waits gap_cycles idle cycles before
//   the next word can go out.
//
// Ports
//   clk                    single clock, rising edge
//   reset                  asynchronous, active-high; clears all state
//   host_valid_in          host offers host_data_in this cycle
//   host_data_in           payload, data_size bits
//   host_err_inject_in     invert the stored parity bit of this push
//   hold_in                downstream stall, only looked at while IDLE
//   host_ready_out         FIFO not full (from the registered count)
//   data_parity_ready_out  one-cycle strobe, high during ISSUE
//   data_parity_out        {payload, parity}; zero when the strobe is low
//   fifo_count_out         words currently buffered, 0..fifo_depth
//   overflow_out           sticky: host pushed while the FIFO was full
module asp_host_tx #(
  parameter int data_size  = 16,
  parameter int fifo_depth = 4,   // power of two, >= 2
  parameter int gap_cycles = 1    // 0..15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          host_valid_in,
  input  logic [data_size-1:0]          host_data_in,
  input  logic                          host_err_inject_in,
  input  logic                          hold_in,
  output logic                          host_ready_out,
  output logic                          data_parity_ready_out,
  output logic [data_size:0]            data_parity_out,
  output logic [$clog2(fifo_depth):0]   fifo_count_out,
  output logic                          overflow_out
);

  localparam int AW = $clog2(fifo_depth);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(fifo_depth);
  localparam logic [3:0]  GAP_LAST   = (gap_cycles > 0) ? 4'(gap_cycles - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          gap_cnt_q, gap_cnt_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [data_size:0]  mem [fifo_depth];

  logic push;
  logic pop;

  // Ready comes from the registered count only. A full FIFO that pops this
  // cycle still refuses the push.
  assign host_ready_out = (count_q != FULL_COUNT);
  assign push           = host_valid_in && host_ready_out;
  // The head leaves at the end of the single ISSUE cycle.
  assign pop            = (state_q == ISSUE);

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (host_valid_in & ~host_ready_out);

    // Pointers are exactly AW bits wide, so they wrap modulo fifo_depth.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if ((count_q != '0) && !hold_in) state_d = ISSUE;
      end
      ISSUE: begin
        gap_cnt_d = '0;
        state_d   = (gap_cycles > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset. Zeroed pointers and count make old
  // contents unreachable, and leaving the reset off keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {host_data_in, (^host_data_in) ^ host_err_inject_in};
  end

  assign data_parity_ready_out = pop;
  assign data_parity_out       = pop ? mem[rd_ptr_q] : '0;
  assign fifo_count_out        = count_q;
  assign overflow_out          = overflow_q;

endmodule
